mole_scheduler: RTL
===================

# mole_scheduler

Sequences the mole LEDs during a round: while the game FSM's `enable_mole_ctrl` is high, it pops one pseudo-random mole at a time. Each mole stays up for a difficulty-dependent time, and the block judges player whacks as hits or misses. It sits between the game control FSM, the debounced button pulses and the score counter, which it drives with one-cycle `hit_pulse`/`miss_pulse`. All timing is counted in `tick_ms` pulses, so the block is clock-frequency independent.

## Interface
Parameters:
- `NUM_MOLES`, 8: number of moles/buttons; power of two, 2..16. `IDX_W = clog2(NUM_MOLES)`.
- `UP_EASY_MS`, 1500: mole up-time, difficulty 0.
- `UP_MED_MS`, 1000: mole up-time, difficulty 1.
- `UP_HARD_MS`, 600: mole up-time, difficulty 2 and 3.
- `GAP_MS`, 300: dark time between moles.
- `FLASH_MS`, 100: all-LED flash after a hit.
- `LFSR_SEED`, 16'hACE1: nonzero LFSR reset value.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: level; from `enable_mole_ctrl`.
- `difficulty_level`, in, 2: selects up-time.
- `tick_ms`, in, 1: one-cycle pulse every 1 ms.
- `whack`, in, NUM_MOLES: one-cycle button pulses, one bit per mole.
- `mole_leds`, out, NUM_MOLES: LED drive, registered.
- `active_idx`, out, IDX_W: index of the current or last mole.
- `hit_pulse`, out, 1: one cycle per hit.
- `miss_pulse`, out, 1: one cycle per miss (timeout or wrong whack).
- `moles_shown`, out, 8: moles popped since leaving IDLE; saturates at 255.

## Operation
- States: IDLE, GAP, UP, FLASH. `ms_cnt` is 11-bit and resets to 0 on every state entry.
- Phase end: `ms_cnt` increments on each `tick_ms`. A phase of length L ends on the tick where `ms_cnt == L-1`, so each phase lasts exactly L ticks.
- IDLE:
  - `mole_leds` = 0.
  - `enable` = 1 moves to GAP.
  - `moles_shown` clears on IDLE→GAP.
- GAP:
  - LEDs = 0.
  - At phase end, moves to UP.
  - Candidate index = `lfsr[IDX_W-1:0]`. If it equals `active_idx`, use (candidate+1) mod NUM_MOLES instead, so consecutive moles always differ.
  - The new index is latched. Up-time is latched from `difficulty_level` at this moment.
  - `moles_shown` increments, saturating at 255.
- UP:
  - `mole_leds` = one-hot(`active_idx`).
  - `whack[active_idx]` = 1: `hit_pulse`, then FLASH. This holds even when other bits are also set; no miss is raised.
  - Any other `whack` bit set alone: `miss_pulse`, stay in UP, timer unaffected.
  - Phase end with no correct whack: `miss_pulse`, then GAP.
  - Correct whack and phase-end tick in the same cycle: hit only.
- FLASH:
  - `mole_leds` = all ones; `whack` is ignored.
  - At phase end (FLASH_MS), moves to GAP.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clock cycle regardless of state.
- `enable` = 0 in any state: next state IDLE, LEDs 0, no pulses. Any in-progress mole is abandoned without a miss. `active_idx` holds its value.
- `difficulty_level` changes mid-mole have no effect until the next GAP→UP transition.

## Timing
- Reset values:
  - state IDLE, `ms_cnt` 0, LFSR = `LFSR_SEED`.
  - `mole_leds` 0, `active_idx` 0, `hit_pulse` 0, `miss_pulse` 0, `moles_shown` 0.
- All outputs are registered.
- An input event sampled at edge N produces the state, LED and pulse change visible after edge N (one-cycle latency).
- `enable` rise to first LED on: 1 cycle to reach GAP, plus GAP_MS ticks, plus 1 cycle.
- `hit_pulse` and `miss_pulse` are never high in the same cycle. Each is high for exactly one cycle per event.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronous).

## Test plan
Directed benches override parameters to UP_EASY_MS=15, UP_MED_MS=10, UP_HARD_MS=6, GAP_MS=3, FLASH_MS=2.

1. Reset, hold `enable`=0 for 100 ticks → `mole_leds`=0, no pulses. Raise `enable` → after 3 ticks LEDs become one-hot and `moles_shown`=1.
2. Difficulty 0, no whack → mole stays up exactly 15 ticks, then one `miss_pulse`, LEDs 0 for 3 ticks, then a new mole whose index ≠ the previous one.
3. Difficulty 2, `whack[active_idx]` on the 2nd tick of UP → `hit_pulse` on the next cycle, LEDs 8'hFF for 2 ticks, then 3-tick GAP.
4. During UP, pulse a wrong bit → `miss_pulse` once, LED unchanged, remaining up-time unchanged. Then pulse the correct bit together with a wrong bit → `hit_pulse` only.
5. Correct whack coincident with the final `tick_ms` of UP → `hit_pulse`=1, `miss_pulse`=0, state FLASH.
6. Drop `enable` mid-UP → LEDs 0 next cycle, no pulse, state IDLE. Re-enable → `moles_shown` restarts from 0. Run 1000 moles and check no two consecutive indices are equal.

Source files
------------

// File: rtl/mole_scheduler.sv
// Mole sequencer: pops one pseudo-random mole per round step, times it in tick_ms
// units and judges whacks as hits or misses for the score counter.
//   state   | meaning
//   IDLE    | round not running, LEDs dark
//   GAP     | dark time between moles
//   UP      | one mole lit, waiting for a whack or timeout
//   FLASH   | all LEDs lit after a hit
module mole_scheduler #(
    parameter int          NUM_MOLES  = 8,
    parameter int          UP_EASY_MS = 1500,
    parameter int          UP_MED_MS  = 1000,
    parameter int          UP_HARD_MS = 600,
    parameter int          GAP_MS     = 300,
    parameter int          FLASH_MS   = 100,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          IDX_W      = $clog2(NUM_MOLES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           difficulty_level,
    input  logic                 tick_ms,
    input  logic [NUM_MOLES-1:0] whack,
    output logic [NUM_MOLES-1:0] mole_leds,
    output logic [IDX_W-1:0]     active_idx,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [7:0]           moles_shown
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GAP   = 2'd1;
    localparam logic [1:0] S_UP    = 2'd2;
    localparam logic [1:0] S_FLASH = 2'd3;

    localparam logic [10:0] GAP_END   = 11'(GAP_MS - 1);
    localparam logic [10:0] FLASH_END = 11'(FLASH_MS - 1);

    logic [1:0]           state;
    logic [10:0]          ms_cnt;
    logic [10:0]          up_len;
    logic [10:0]          up_sel;
    logic [15:0]          lfsr;
    logic                 lfsr_fb;
    logic [IDX_W-1:0]     cand_idx;
    logic [IDX_W-1:0]     next_idx;
    logic [NUM_MOLES-1:0] next_onehot;
    logic                 gap_end;
    logic                 up_end;
    logic                 flash_end;
    logic                 hit_now;

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign cand_idx = lfsr[IDX_W-1:0];
    // Bump a repeated candidate so the same mole never pops twice in a row.
    assign next_idx    = (cand_idx == active_idx) ? cand_idx + IDX_W'(1) : cand_idx;
    assign next_onehot = NUM_MOLES'(1) << next_idx;

    assign gap_end   = tick_ms && (ms_cnt == GAP_END);
    assign up_end    = tick_ms && (ms_cnt == up_len - 11'd1);
    assign flash_end = tick_ms && (ms_cnt == FLASH_END);
    assign hit_now   = whack[active_idx];

    always_comb begin
        up_sel = 11'(UP_HARD_MS);
        case (difficulty_level)
            2'd0:    up_sel = 11'(UP_EASY_MS);
            2'd1:    up_sel = 11'(UP_MED_MS);
            default: up_sel = 11'(UP_HARD_MS);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ms_cnt      <= '0;
            up_len      <= 11'(UP_EASY_MS);
            lfsr        <= LFSR_SEED;
            mole_leds   <= '0;
            active_idx  <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            moles_shown <= '0;
        end else begin
            lfsr       <= {lfsr[14:0], lfsr_fb};
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            if (!enable) begin
                state     <= S_IDLE;
                ms_cnt    <= '0;
                mole_leds <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state       <= S_GAP;
                        ms_cnt      <= '0;
                        mole_leds   <= '0;
                        moles_shown <= '0;
                    end
                    S_GAP: begin
                        if (gap_end) begin
                            state      <= S_UP;
                            ms_cnt     <= '0;
                            active_idx <= next_idx;
                            up_len     <= up_sel;
                            mole_leds  <= next_onehot;
                            if (moles_shown != 8'hFF) begin
                                moles_shown <= moles_shown + 8'd1;
                            end
                        end else if (tick_ms) begin
                            ms_cnt <= ms_cnt + 11'd1;
                        end
                    end
                    S_UP: begin
                        // A correct whack wins over both wrong bits and the timeout tick.
                        if (hit_now) begin
                            hit_pulse <= 1'b1;
                            state     <= S_FLASH;
                            ms_cnt    <= '0;
                            mole_leds <= '1;
                        end else if (up_end) begin
                            miss_pulse <= 1'b1;
                            state      <= S_GAP;
                            ms_cnt     <= '0;
                            mole_leds  <= '0;
                        end else begin
                            if (tick_ms) begin
                                ms_cnt <= ms_cnt + 11'd1;
                            end
                            if (|whack) begin
                                miss_pulse <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (flash_end) begin
                            state     <= S_GAP;
                            ms_cnt    <= '0;
                            mole_leds <= '0;
                        end else if (tick_ms) begin
                            ms_cnt <= ms_cnt + 11'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
